// File: rtl/sha256_msg_sched_if.sv
// Handshake bundle between the SHA-256 message scheduler and its neighbours.
//   START                    : one-cycle block start request
//   IN_DATA/IN_VALID/IN_READY: message word stream M[0..15] into the scheduler
//   W_DATA/W_IDX/W_VALID/W_READY : schedule word stream W[t] out of the scheduler
//   BUSY, DONE               : status (BUSY while a block is in flight, DONE pulse at end)
//   ABORT                    : synchronous cancel, present only with SHA_SCHED_ABORT_EN
// Modports: master = block-padding front end / round datapath side, slave = scheduler.
interface sha256_msg_sched_if;
  logic        START;
  logic [31:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] W_DATA;
  logic [5:0]  W_IDX;
  logic        W_VALID;
  logic        W_READY;
  logic        BUSY;
  logic        DONE;
`ifdef SHA_SCHED_ABORT_EN
  logic        ABORT;

  modport master (
    output START, IN_DATA, IN_VALID, W_READY, ABORT,
    input  IN_READY, W_DATA, W_IDX, W_VALID, BUSY, DONE
  );
  modport slave (
    input  START, IN_DATA, IN_VALID, W_READY, ABORT,
    output IN_READY, W_DATA, W_IDX, W_VALID, BUSY, DONE
  );
`else
  modport master (
    output START, IN_DATA, IN_VALID, W_READY,
    input  IN_READY, W_DATA, W_IDX, W_VALID, BUSY, DONE
  );
  modport slave (
    input  START, IN_DATA, IN_VALID, W_READY,
    output IN_READY, W_DATA, W_IDX, W_VALID, BUSY, DONE
  );
`endif
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule sequencer for one 512-bit block.
// Accepts M[0..15] serially, then streams W[0..ROUNDS-1] over valid/ready,
// expanding W[16..] from a 16-entry circular word buffer.
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : sha256_msg_sched_if.slave (START, IN_*, W_*, BUSY, DONE[, ABORT])
// Parameter ROUNDS: W words produced per block, legal range 17..64.
// Optional macro SHA_SCHED_ABORT_EN adds the synchronous ABORT input.
module sha256_msg_sched #(
  parameter int unsigned ROUNDS = 64
) (
  input logic                    CLK,
  input logic                    RST_N,
  sha256_msg_sched_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FIN} state_t;

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  state_t      state, state_n;
  logic [5:0]  t;
  logic [31:0] w_data_q;
  logic [5:0]  w_idx_q;
  logic        w_valid_q;
  logic        done_q;
  logic [31:0] wbuf [16];

  logic        out_free;
  logic        start_ok;
  logic        load_acc;
  logic        exp_issue;
  logic        fin_xfer;
  logic        abort_now;

  logic [3:0]  slot, s2, s7, s15;
  logic [31:0] wt;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Operand slots relative to the slot being written; (t-15) mod 16 == t+1.
  assign slot = t[3:0];
  assign s2   = slot - 4'd2;
  assign s7   = slot - 4'd7;
  assign s15  = slot + 4'd1;
  assign wt   = sig1(wbuf[s2]) + wbuf[s7] + sig0(wbuf[s15]) + wbuf[slot];

  assign out_free = !w_valid_q || bus.W_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_ok  = 1'b0;
    load_acc  = 1'b0;
    exp_issue = 1'b0;
    fin_xfer  = 1'b0;
    abort_now = 1'b0;
    unique case (state)
      IDLE: begin
        // The DONE cycle is spent in IDLE; a START there is deliberately dropped.
        if (bus.START && !done_q) begin
          start_ok = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        if (bus.IN_VALID && out_free) begin
          load_acc = 1'b1;
          if (t == 6'd15) state_n = EXPAND;
        end
      end
      EXPAND: begin
        if (out_free) begin
          exp_issue = 1'b1;
          if (t == T_LAST) state_n = FIN;
        end
      end
      FIN: begin
        if (bus.W_READY) begin
          fin_xfer = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef SHA_SCHED_ABORT_EN
    if (bus.ABORT && state != IDLE) begin
      abort_now = 1'b1;
      start_ok  = 1'b0;
      load_acc  = 1'b0;
      exp_issue = 1'b0;
      fin_xfer  = 1'b0;
      state_n   = IDLE;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t         <= '0;
      w_data_q  <= '0;
      w_idx_q   <= '0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort_now) begin
      t         <= '0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= fin_xfer;
      if (load_acc) begin
        w_data_q  <= bus.IN_DATA;
        w_idx_q   <= t;
        w_valid_q <= 1'b1;
        t         <= t + 6'd1;
      end else if (exp_issue) begin
        w_data_q  <= wt;
        w_idx_q   <= t;
        w_valid_q <= 1'b1;
        t         <= t + 6'd1;
      end else if (fin_xfer) begin
        w_valid_q <= 1'b0;
        t         <= '0;
      end else if (w_valid_q && bus.W_READY) begin
        w_valid_q <= 1'b0;
      end
      if (start_ok) t <= '0;
    end
  end

  // Buffer holds no reset value; W[t-16] is read above before this overwrite lands.
  always_ff @(posedge CLK) begin
    if (load_acc)       wbuf[slot] <= bus.IN_DATA;
    else if (exp_issue) wbuf[slot] <= wt;
  end

  assign bus.IN_READY = (state == LOAD) && out_free;
  assign bus.W_DATA   = w_data_q;
  assign bus.W_IDX    = w_idx_q;
  assign bus.W_VALID  = w_valid_q;
  assign bus.BUSY     = (state != IDLE);
  assign bus.DONE     = done_q;

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Sequences the SHA-256 message-schedule expansion for one 512-bit block.
- Accepts 16 message words serially, then streams W[0..ROUNDS-1] to the compression round logic over a valid/ready interface.
- Holds a 16-entry circular word buffer and computes the σ0/σ1 expansion internally.
- Sits between the block-padding front end and the round datapath that uses the Σ0 module.

Parameters:
- ROUNDS, 64, number of W words produced per block; legal range 17..64.

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- START  input  1  one-cycle pulse; begins a block when idle
- IN_DATA  input  32  message word M[i], i=0..15 in order
- IN_VALID  input  1  IN_DATA valid
- IN_READY  output  1  block accepts IN_DATA this cycle
- W_DATA  output  32  schedule word W[t]
- W_IDX  output  6  t of W_DATA
- W_VALID  output  1  W_DATA/W_IDX valid
- W_READY  input  1  consumer takes W_DATA this cycle
- BUSY  output  1  state != IDLE
- DONE  output  1  one-cycle pulse after W[ROUNDS-1] transfers

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values: state=IDLE, W_VALID=0, W_DATA=0, W_IDX=0, IN_READY=0, BUSY=0, DONE=0, t=0. Buffer contents are don't-care.
- Assertion of RST_N mid-block aborts immediately. No partial output survives.
- States: IDLE, LOAD, EXPAND, FIN.
  - IDLE: START=1 -> LOAD, t=0. START in any other state is ignored.
  - LOAD: IN_READY = (!W_VALID || W_READY), combinational.
  - LOAD accept (IN_VALID && IN_READY): buf[t mod 16]<=IN_DATA; next cycle W_DATA=IN_DATA, W_IDX=t, W_VALID=1; t++.
  - LOAD exit: after accepting t=15 -> EXPAND.
  - EXPAND: IN_READY=0. Output register free (!W_VALID || W_READY) -> W_DATA<=Wt, W_IDX<=t, W_VALID<=1, buf[t mod 16]<=Wt, t++.
  - EXPAND exit: after issuing t=ROUNDS-1 -> FIN.
  - FIN: waits for the final W transfer; then DONE=1 for one cycle, W_VALID=0, -> IDLE.
- Output latency: one cycle from input acceptance (LOAD) or slot availability (EXPAND) to W_VALID.
  - Continuous W_READY=1 gives one W word per cycle with no bubbles between LOAD and EXPAND.
- Wt = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] mod 2^32.
  - Operands are read from buf[(t-k) mod 16].
  - W[t-16] occupies the slot being overwritten; read-before-write in the same cycle.
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Sum carries beyond bit 31 are discarded.
- Handshake rules:
  - W_DATA/W_IDX hold stable while W_VALID=1 and W_READY=0.
  - W_VALID never drops without a transfer, except on reset or abort.
- Wrap-around: t counts 0..ROUNDS-1. Buffer index is t[3:0].
- Simultaneous events:
  - Transfer of the last word and DONE: DONE asserts the cycle after the transfer.
  - START in the DONE cycle is ignored. START the following cycle is accepted.
- BUSY=1 in LOAD, EXPAND and FIN.

Optional Feature:
- Macro SHA_SCHED_ABORT_EN.
- Defined: adds input ABORT (1 bit, synchronous).
  - ABORT=1 in any non-IDLE state -> next cycle state=IDLE, W_VALID=0, IN_READY=0, t=0, no DONE.
  - ABORT has priority over START and over transfers in the same cycle.
- Undefined: no ABORT port; the only way to cancel a block is RST_N.

Test Plan:
- "abc" block: M0=0x61626380, M1..M14=0, M15=0x00000018, W_READY=1 -> W0=0x61626380, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB; W_IDX 0..63 contiguous; DONE one cycle after W63 transfer; 64 W words total.
- All-ones block: M0..M15=0xFFFFFFFF -> W16=0x203FFFFC.
- Backpressure: "abc" block, W_READY toggling 1,0,0,1 repeatedly.
  - W_DATA/W_IDX stable while stalled.
  - IN_READY=0 while W_VALID && !W_READY.
  - Sequence identical to the no-stall run.
- Reset mid-op: drop RST_N during EXPAND at t=30.
  - All outputs return to reset values asynchronously.
  - A following START plus "abc" block reproduces W63=0x12B1EDEB.
- START pulsed during LOAD and EXPAND -> no effect; t and output sequence unchanged.
- ROUNDS=17: exactly 17 words, W16 per "abc" =0x61626380, then DONE.
- With SHA_SCHED_ABORT_EN, ABORT at t=20 -> W_VALID=0 next cycle, no DONE, BUSY=0.
